// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit that owns HI/LO.
// Handshake: start is a single-cycle request that is accepted only while
// busy is low (state IDLE); busy is high from the accepting edge through
// the edge that writes HI/LO, and done pulses for the cycle after that
// write. MTHI/MTLO complete at the accepting edge without raising busy.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   // state is kept as a named enum signal so checkers can bind to it
   state_t state;
   state_t state_nxt;
   logic   busy_nxt;
   logic   done_nxt;

   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
   logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
   logic               is_div;
   logic               sign_lo;  // product sign (MUL) or quotient sign (DIV)
   logic               sign_hi;  // remainder sign (DIV only)

   logic               signed_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               last_iter;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Operand conditioning: signed ops iterate on magnitudes, signs fixed at the end
   assign signed_op = ~op[0];
   assign a_neg     = signed_op & a[WIDTH-1];
   assign b_neg     = signed_op & b[WIDTH-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;
   assign last_iter = (count == CNT_W'(WIDTH - 1));

   // One shift-add step: add multiplicand into the upper half when multiplier LSB is set
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
   // One restoring step: shift next dividend bit into the remainder, trial-subtract divisor
   assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opnd};

   // Sign fixup values written to HI/LO in the FIX cycle
   assign prod_fix = sign_lo ? -acc : acc;
   assign quo_fix  = sign_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = sign_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   // State register plus registered busy/done
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state: only IDLE accepts work; each iteration state runs WIDTH cycles
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && !op[2]) state_nxt = op[1] ? S_DIV : S_MUL;
         end
         S_MUL, S_DIV: begin
            if (last_iter) state_nxt = S_FIX;
         end
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs: busy follows the state being entered, done follows leaving FIX
   always_comb begin
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state == S_FIX);
   end

   // Datapath: operand capture, iteration, and the single HI/LO write point
   always_ff @(posedge clk) begin
      if (!rst) begin
         count   <= '0;
         acc     <= '0;
         opnd    <= '0;
         is_div  <= 1'b0;
         sign_lo <= 1'b0;
         sign_hi <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               count <= '0;
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        acc     <= {{WIDTH{1'b0}}, b_mag};
                        opnd    <= a_mag;
                        is_div  <= 1'b0;
                        sign_lo <= a_neg ^ b_neg;
                        sign_hi <= 1'b0;
                     end
                     OP_DIV, OP_DIVU: begin
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        opnd    <= b_mag;
                        is_div  <= 1'b1;
                        // A zero divisor yields an all-ones quotient and the dividend
                        // magnitude as remainder; suppressing the quotient negate keeps
                        // LO all-ones, and the remainder negate restores the raw dividend.
                        sign_lo <= (b != '0) & (a_neg ^ b_neg);
                        sign_hi <= a_neg;
                     end
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               count <= count + CNT_W'(1);
               if (acc[0]) acc <= {mul_sum, acc[WIDTH-1:1]};
               else        acc <= {1'b0, acc[2*WIDTH-1:1]};
            end
            S_DIV: begin
               count <= count + CNT_W'(1);
               if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else                  acc <= {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
            S_FIX: begin
               count <= '0;
               if (is_div) begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: count <= '0;
         endcase
      end
   end

endmodule
